burrito_fetch: RTL and testbench
================================

// Module: burrito_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of the Burrito datapath.
//  - Walks a program counter over the asynchronous instruction RAM (ram_async, combinational read).
//  - Buffers fetched 20-bit words in a 2-entry prefetch queue.
//  - Presents the head word to Burrito, split into WEnable/Op/D1/D2/RD, under a valid/ready handshake.
//  - Runs one program pass per start pulse: addresses 0..LAST_ADDR.
// PARAMETERS
//  ADDR_W     3   instruction RAM address width
//  INSTR_W    20  instruction word width; field split below is fixed for 20
//  LAST_ADDR  5   final address fetched in a pass; legal range 0..2**ADDR_W-1
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       begin a pass; sampled only in IDLE or DONE
//  imem_addr    out  ADDR_W  read address to ram_async; always equals pc
//  imem_data    in   INSTR_W ram_async data_out for imem_addr, same cycle
//  instr_valid  out  1       head entry available to Burrito
//  instr_ready  in   1       Burrito accepts head this cycle
//  WEnable      out  1       head[19]
//  Op           out  4       head[18:15]
//  D1           out  5       head[14:10]
//  D2           out  5       head[9:5]
//  RD           out  5       head[4:0]
//  pc           out  ADDR_W  next address to fetch
//  busy         out  1       state is RUN or DRAIN
//  done         out  1       state is DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=0, queue count=0, instr_valid=0.
//    All field outputs read 0; busy=0, done=0.
//  FSM:
//    IDLE  -start-> RUN (pc=0).
//    RUN   -push of LAST_ADDR-> DRAIN.
//    DRAIN -queue empty-> DONE.
//    DONE  -start-> RUN (pc cleared to 0).
//  start is ignored in RUN and DRAIN.
//  Push (RUN only): on a clock edge where count<2, or count==2 with a pop in the same cycle:
//    imem_data is written at the tail; pc increments.
//    The LAST_ADDR push moves the FSM to DRAIN; pc then holds at LAST_ADDR+1, truncated to ADDR_W.
//  pc never wraps inside a pass; imem_addr=pc combinationally.
//  Pop: instr_valid && instr_ready on a clock edge.
//  Push and pop in the same cycle: count unchanged, order preserved (FIFO).
//  instr_valid = (count!=0). Fields are driven combinationally from the head entry.
//    Fields are 0 when count==0.
//    Fields hold stable while instr_valid && !instr_ready.
//  Latency: first word valid 1 cycle after start is sampled.
//    Throughput 1 word/cycle with instr_ready held high.
//  Empty pop: impossible by construction.
//  Full without pop: no push, pc holds.
//  Reset mid-pass: in-flight words are discarded; no partial output survives.
// STRUCTURE
//  burrito_pkg: field position constants (WE_BIT=19, OP_HI/LO=18/15, D1 14/10, D2 9/5, RD 4/0).
//  burrito_pkg: FSM state encoding (IDLE, RUN, DRAIN, DONE).
//  One sub-module: fetch_fifo2 (2-entry FIFO: push/pop/full/empty/count, async active-low reset).
//  FSM, pc and field decode stay in burrito_fetch.
// TESTING
//  Testbench instantiates ram_async preloaded with 6 known words; clk period 10ns.
//  1. RAM[0]=20'h8A41F, start pulse, instr_ready=1
//       -> next cycle instr_valid=1, WEnable=1, Op=4'h1, D1=5'h09, D2=5'h00, RD=5'h1F.
//       -> all 6 words are delivered in order, one per cycle; done=1 after the 6th pop.
//  2. instr_ready=0 after start
//       -> pc stops at 2, count=2; head stays RAM[0] unchanged for 10 cycles.
//       -> raising ready drains 0..5 in order.
//  3. Toggle instr_ready 1/0 every cycle
//       -> no word is lost or duplicated; the scoreboard matches RAM[0..5] exactly.
//  4. Assert rst_n=0 mid-pass at pc=3
//       -> instr_valid=0, pc=0, busy=0 immediately (async), with no clk edge.
//  5. Pulse start in RUN -> ignored.
//       In DONE -> pc restarts at 0 and the pass repeats identically.
//  6. LAST_ADDR=7, ADDR_W=3
//       -> 8 words are delivered; pc reads 0 in DRAIN; no re-fetch of address 0 occurs.

Source files
------------

// File: rtl/burrito_pkg.sv
// burrito_pkg: instruction field positions and fetch FSM encoding shared by the fetch stage.
package burrito_pkg;
    localparam int WE_BIT = 19;
    localparam int OP_HI  = 18;
    localparam int OP_LO  = 15;
    localparam int D1_HI  = 14;
    localparam int D1_LO  = 10;
    localparam int D2_HI  = 9;
    localparam int D2_LO  = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 0;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry FIFO; the caller never pushes when full without a pop, nor pops when empty.
module fetch_fifo2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         rd_q, wr_q;
    logic [1:0]   cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            rd_q  <= rd_q ^ pop_i;
            wr_q  <= wr_q ^ push_i;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/burrito_fetch.sv
// burrito_fetch: walks pc over the instruction RAM once per start pulse, buffers words in a
// 2-entry queue and presents the head to Burrito as decoded fields under valid/ready.
module burrito_fetch
    import burrito_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int INSTR_W   = 20,
    parameter int LAST_ADDR = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               WEnable,
    output logic [3:0]         Op,
    output logic [4:0]         D1,
    output logic [4:0]         D2,
    output logic [4:0]         RD,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [1:0]         count;
    logic               empty, full, push, pop;
    logic [INSTR_W-1:0] dout, head;
    assign empty       = count == 2'd0;
    assign full        = count == 2'd2;
    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;
    // a full queue still accepts a word when the head leaves on the same edge
    assign push        = state_q == RUN && (!full || pop);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign busy        = state_q == RUN || state_q == DRAIN;
    assign done        = state_q == DONE;
    assign head        = empty ? '0 : dout;
    assign WEnable     = head[WE_BIT];
    assign Op          = head[OP_HI:OP_LO];
    assign D1          = head[D1_HI:D1_LO];
    assign D2          = head[D2_HI:D2_LO];
    assign RD          = head[RD_HI:RD_LO];
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RUN;
                pc_d    = '0;
            end
            RUN: if (push) begin
                pc_d = pc_q + ADDR_W'(1);
                if (pc_q == LAST) state_d = DRAIN;
            end
            DRAIN: if (empty) state_d = DONE;
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    fetch_fifo2 #(.W(INSTR_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (imem_data),
        .dout_o  (dout),
        .count_o (count)
    );
endmodule

// File: tb/tb_burrito_fetch.sv
// tb_burrito_fetch: scoreboard bench; stimulus queues expected words, monitors pop and compare on accepted handshakes.
module tb_burrito_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] ram [8];
    int checks = 0;
    int failures = 0;
    logic [19:0] q5 [$];
    logic [19:0] q7 [$];

    logic start5 = 1'b0, rdy5 = 1'b0, start7 = 1'b0, rdy7 = 1'b0;
    logic [2:0] addr5, pc5, addr7, pc7;
    logic [19:0] data5, data7;
    logic v5, we5, busy5, done5, v7, we7, busy7, done7;
    logic [3:0] op5, op7;
    logic [4:0] d15, d25, rd5, d17, d27, rd7;

    assign data5 = ram[addr5];
    assign data7 = ram[addr7];

    burrito_fetch #(.ADDR_W(3), .INSTR_W(20), .LAST_ADDR(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .imem_addr(addr5), .imem_data(data5),
        .instr_valid(v5), .instr_ready(rdy5), .WEnable(we5), .Op(op5), .D1(d15), .D2(d25),
        .RD(rd5), .pc(pc5), .busy(busy5), .done(done5));

    burrito_fetch #(.ADDR_W(3), .INSTR_W(20), .LAST_ADDR(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .imem_addr(addr7), .imem_data(data7),
        .instr_valid(v7), .instr_ready(rdy7), .WEnable(we7), .Op(op7), .D1(d17), .D2(d27),
        .RD(rd7), .pc(pc7), .busy(busy7), .done(done7));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && v5 && rdy5) begin
            if (q5.size() == 0) chk("sb5_unexpected_word", 32'({we5, op5, d15, d25, rd5}), 32'hFFFFFFFF);
            else begin
                logic [19:0] e;
                e = q5.pop_front();
                chk("sb5_word", 32'({we5, op5, d15, d25, rd5}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v7 && rdy7) begin
            if (q7.size() == 0) chk("sb7_unexpected_word", 32'({we7, op7, d17, d27, rd7}), 32'hFFFFFFFF);
            else begin
                logic [19:0] e;
                e = q7.pop_front();
                chk("sb7_word", 32'({we7, op7, d17, d27, rd7}), 32'(e));
                if (q7.size() == 0) begin
                    chk("pc7_wrapped_in_drain", 32'(pc7), 32'd0);
                    chk("busy7_in_drain", 32'(busy7), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pass5();
        for (int i = 0; i < 6; i++) q5.push_back(ram[i]);
    endtask

    task automatic pulse5();
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
    endtask

    task automatic wait_done5(input string name);
        int n = 0;
        while (!done5 && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(done5), 32'd1);
        chk({name, "_sb_empty"}, 32'(q5.size()), 32'd0);
    endtask

    initial begin
        ram[0] = 20'h8A41F; ram[1] = 20'h12345; ram[2] = 20'h6789A; ram[3] = 20'hBCDEF;
        ram[4] = 20'h0F0F0; ram[5] = 20'hFFFFF; ram[6] = 20'h55555; ram[7] = 20'hAAAAA;
        repeat (2) tick();
        chk("rst_valid", 32'(v5), 32'd0);
        chk("rst_pc", 32'(pc5), 32'd0);
        chk("rst_busy", 32'(busy5), 32'd0);
        chk("rst_done", 32'(done5), 32'd0);
        chk("rst_fields", 32'({we5, op5, d15, d25, rd5}), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: streaming with ready held high
        rdy5 = 1'b1;
        expect_pass5();
        pulse5();
        tick();
        chk("t1_valid", 32'(v5), 32'd1);
        chk("t1_we", 32'(we5), 32'd1);
        chk("t1_op", 32'(op5), 32'h1);
        chk("t1_d1", 32'(d15), 32'h09);
        chk("t1_d2", 32'(d25), 32'h00);
        chk("t1_rd", 32'(rd5), 32'h1F);
        wait_done5("t1_done");

        // 2: stall with ready low, queue fills and pc stops
        rdy5 = 1'b0;
        expect_pass5();
        pulse5();
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t2_pc_hold", 32'(pc5), 32'd2);
            chk("t2_head_hold", 32'({we5, op5, d15, d25, rd5}), 32'(ram[0]));
            tick();
        end
        rdy5 = 1'b1;
        wait_done5("t2_done");

        // 3: ready toggles every cycle
        expect_pass5();
        pulse5();
        for (int i = 0; i < 40 && !done5; i++) begin
            rdy5 = ~rdy5;
            tick();
        end
        rdy5 = 1'b1;
        wait_done5("t3_done");

        // 4: async reset mid-pass
        expect_pass5();
        pulse5();
        for (int i = 0; i < 10 && pc5 != 3'd3; i++) tick();
        chk("t4_reached_pc3", 32'(pc5), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_valid", 32'(v5), 32'd0);
        chk("t4_pc", 32'(pc5), 32'd0);
        chk("t4_busy", 32'(busy5), 32'd0);
        q5.delete();
        #1 rst_n = 1'b1;
        tick();
        chk("t4_idle_valid", 32'(v5), 32'd0);

        // 5: start ignored in RUN, honoured in DONE
        expect_pass5();
        pulse5();
        tick();
        pulse5();
        wait_done5("t5_done_a");
        expect_pass5();
        pulse5();
        chk("t5_pc_restart", 32'(pc5), 32'd0);
        wait_done5("t5_done_b");

        // 6: LAST_ADDR at top of address space
        rdy7 = 1'b1;
        for (int i = 0; i < 8; i++) q7.push_back(ram[i]);
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        for (int i = 0; i < 60 && !done7; i++) tick();
        chk("t6_done", 32'(done7), 32'd1);
        chk("t6_sb_empty", 32'(q7.size()), 32'd0);
        repeat (3) tick();
        chk("t6_no_refetch", 32'(v7), 32'd0);
        chk("t6_pc_done", 32'(pc7), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
